// File: rtl/nn_fixed_pkg.sv
// nn_fixed_pkg: shared fixed-point helpers and sequencer state encoding
package nn_fixed_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;
    function automatic int dw(input int int_part, input int fract_part);
        return int_part + fract_part;
    endfunction
    // ReLU reduces to "force zero when enabled and negative"
    function automatic logic relu_kill(input logic en, input logic sign);
        return en & sign;
    endfunction
endpackage

// File: rtl/fixed_mac.sv
// fixed_mac: combinational signed fixed-point multiply-accumulate, truncating, wrapping
module fixed_mac #(
    parameter int INT_PART   = 3,
    parameter int FRACT_PART = 2,
    localparam int DW        = INT_PART + FRACT_PART
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    output logic [DW-1:0] y
);
    logic [2*DW-1:0] p;
    logic [2*DW:0]   s;
    assign p = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
    assign s = {p[2*DW-1], p} + {{(DW+1-FRACT_PART){c[DW-1]}}, c, {FRACT_PART{1'b0}}};
    // Sign comes from the full-width sum so overflow wraps only the magnitude bits
    assign y = {s[2*DW], s[INT_PART+2*FRACT_PART-2:FRACT_PART]};
endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: drives one MAC through an N-term dot product with bias and optional ReLU
module mac_sequencer
    import nn_fixed_pkg::*;
#(
    parameter int INT_PART   = 3,
    parameter int FRACT_PART = 2,
    parameter int LEN_W      = 8,
    localparam int DW        = dw(INT_PART, FRACT_PART)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [DW-1:0]    bias,
    input  logic             relu_en,
    output logic             busy,
    output logic [LEN_W-1:0] x_addr,
    output logic [LEN_W-1:0] w_addr,
    output logic             rd_en,
    input  logic [DW-1:0]    x_rdata,
    input  logic [DW-1:0]    w_rdata,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    state_t           state, state_n;
    logic [LEN_W-1:0] cnt, len_q;
    logic             relu_q, rd_en_d;
    logic [DW-1:0]    acc, mac_y;

    fixed_mac #(.INT_PART(INT_PART), .FRACT_PART(FRACT_PART)) u_mac (
        .a(x_rdata),
        .b(w_rdata),
        .c(acc),
        .y(mac_y)
    );

    always_comb begin
        state_n = state == IDLE  ? (start ? (len != '0 ? FETCH : OUT) : IDLE) :
                  state == FETCH ? (cnt == len_q - 1'b1 ? DRAIN : FETCH) :
                  state == DRAIN ? OUT :
                                   (out_ready ? IDLE : OUT);
    end

    assign rd_en     = state == FETCH;
    assign busy      = state != IDLE;
    assign out_valid = state == OUT;
    // cnt stops on the last issued address, so it doubles as the held read address
    assign x_addr    = cnt;
    assign w_addr    = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            len_q    <= '0;
            relu_q   <= 1'b0;
            rd_en_d  <= 1'b0;
            out_data <= '0;
        end else begin
            state   <= state_n;
            rd_en_d <= rd_en;
            if (state == IDLE && start) begin
                len_q  <= len;
                relu_q <= relu_en;
                acc    <= bias;
                if (len != '0) cnt <= '0;
                else out_data <= relu_kill(relu_en, bias[DW-1]) ? '0 : bias;
            end else if (rd_en_d) begin
                acc <= mac_y;
            end
            if (rd_en && state_n == FETCH) cnt <= cnt + 1'b1;
            if (state == DRAIN) out_data <= relu_kill(relu_q, mac_y[DW-1]) ? '0 : mac_y;
        end
    end
endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Sequences one fixed-point MAC unit through an N-term dot product, acc = bias + sum(x[k]*w[k]) for k = 0..N-1, which forms one neuron evaluation.
- Fetches x and w operands from two synchronous-read memories (1-cycle read latency).
- Feeds each operand pair and the running accumulator into the MAC.
- Applies optional ReLU to the final sum.
- Presents the result on a valid/ready output port to the layer controller.

Parameters:
INT_PART, 3, integer bits of the signed fixed-point format (including sign)
FRACT_PART, 2, fractional bits; data width DW = INT_PART+FRACT_PART
LEN_W, 8, width of the length field and of both memory addresses; N max = 2^LEN_W-1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  pulse; sampled only in IDLE
len  in  LEN_W  number of terms N, sampled with start
bias  in  DW  signed initial accumulator value, sampled with start
relu_en  in  1  apply ReLU to result, sampled with start
busy  out  1  high from the cycle after start is accepted until the result handshake completes
x_addr  out  LEN_W  input-vector memory read address
w_addr  out  LEN_W  weight memory read address (always equal to x_addr)
rd_en  out  1  read strobe to both memories
x_rdata  in  DW  x data, valid 1 cycle after rd_en
w_rdata  in  DW  w data, valid 1 cycle after rd_en
out_data  out  DW  signed result
out_valid  out  1  result valid
out_ready  in  1  consumer ready

Behaviour:
- Reset values: busy=0, rd_en=0, x_addr=w_addr=0, out_data=0, out_valid=0. Internal state: IDLE, acc=0, cnt=0.
- States: IDLE, FETCH, DRAIN, OUT.
- IDLE:
  - If start=1, latch len, bias and relu_en, load acc<=bias and cnt<=0.
  - Go to FETCH if len!=0, else OUT (with out_data computed from bias).
- FETCH:
  - Drive rd_en=1 and addr=cnt, then increment cnt.
  - When cnt==N-1 is issued, go to DRAIN.
- Operand pipeline: a registered flag rd_en_d marks valid rdata. In every cycle with rd_en_d=1, acc <= MAC(x_rdata, w_rdata, acc).
- DRAIN: performs the last accumulate (rd_en_d=1, rd_en=0), then goes to OUT.
- OUT:
  - out_data = (relu_en && acc[DW-1]) ? 0 : acc; registered on entry.
  - out_valid=1 and holds stable until out_ready=1.
  - On the handshake go to IDLE; out_valid drops the next cycle.
- Latency for start accepted at cycle 0:
  - Addresses 0..N-1 are issued in cycles 1..N.
  - Accumulates occur in cycles 2..N+1.
  - out_valid is asserted in cycle N+2.
  - len=0: out_valid is asserted in cycle 1.
- MAC arithmetic: this is the team's MAC rule and is bit-exact, with no saturation.
  - P = a*b at 2*DW bits.
  - S = P + (c<<FRACT_PART) at 2*DW+1 bits.
  - result = {S[2*DW], S[INT_PART+2*FRACT_PART-2 : FRACT_PART]}.
  - Fraction LSBs are truncated toward -inf. Magnitude overflow wraps; the sign is taken from the full sum.
- Boundaries:
  - start while busy or in OUT is ignored.
  - start and out_ready high in the same OUT cycle: the handshake completes and start is ignored (the new start is seen only in IDLE).
  - N = 2^LEN_W-1: cnt never wraps.
  - rst in any state: return to IDLE with reset values next cycle. Any pending result is discarded and any in-flight rdata is ignored.
- x_addr and w_addr hold their last value when rd_en=0.

Decomposition:
- Package nn_fixed_pkg holds:
  - DW derivation
  - the state enum typedef (IDLE/FETCH/DRAIN/OUT)
  - a relu function
- One sub-module: the existing MAC datapath (MAC with int_part=INT_PART, fract_part=FRACT_PART), instantiated combinationally between rdata and acc.
- The controller contains no other arithmetic.

Test Plan:
- Format Q3.2. x=[1.0,2.0,0.5] (4,8,2), w=[0.5,1.0,2.0] (2,4,8), bias=0, N=3 -> out_data=5'b01110 (3.5); out_valid in cycle 5 after start.
- x=[-1.0] (5'b11100), w=[0.75] (5'b00011), bias=0.25 (5'b00001) -> out_data=5'b11110 (-0.5). Repeat with relu_en=1 -> 5'b00000.
- Overflow: x=[2.0,2.0], w=[1.5,1.5], bias=0 -> intermediate 3.0, final wraps to 5'b01000 (2.0), bit-exact to the MAC rule.
- len=0, bias=5'b10110 (-2.5), relu_en=0 -> out_valid in cycle 1, out_data=5'b10110, and rd_en never asserted.
- Backpressure: hold out_ready=0 for 4 cycles -> out_data and out_valid stable. Pulse start during the hold -> ignored. Then set out_ready=1 -> IDLE, and the next start runs normally.
- Assert rst mid-FETCH (N=10, cycle 4) -> next cycle busy=0, out_valid=0, rd_en=0. A new start then gives a correct result unaffected by the aborted run.
